// File: rtl/keypad_pw_buffer.sv
// -----------------------------------------------------------------------------
// keypad_pw_buffer
// Password-entry buffer for the trick lock. It collects DIGITS key codes from the
// keypad decoder into a packed register, storing one digit for each accepted key
// strobe. It also supports backspace, full/done flags and a lock freeze. A
// partial entry is discarded after an inactivity timeout.
//
// Parameters
//   DIGITS       number of password digits (>=1)
//   DW           bits per digit (key code width)
//   TIMEOUT_CYC  idle cycles in ENTRY before a partial entry is discarded;
//                0 disables the timeout
//   CNT_W        digit counter width (derived)
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   key_valid    one-cycle strobe: keyvalue holds a new digit
//   keyvalue     key code, sampled only with key_valid
//   backspace    one-cycle strobe: delete the last entered digit
//   clear        level: wipe the whole buffer
//   lockkey      level: freeze the buffer, ignore keys and backspace
//   pw_bus       digit i at pw_bus[i*DW +: DW], digit 0 = first entered
//   digit_cnt    number of digits currently held (0..DIGITS)
//   full         digit_cnt == DIGITS
//   entry_done   one-cycle pulse when the DIGITS-th digit is stored
//   timeout      one-cycle pulse when a partial entry is discarded
// -----------------------------------------------------------------------------
module keypad_pw_buffer #(
  parameter int DIGITS      = 4,
  parameter int DW          = 4,
  parameter int TIMEOUT_CYC = 1000,
  localparam int CNT_W      = $clog2(DIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_valid,
  input  logic [DW-1:0]        keyvalue,
  input  logic                 backspace,
  input  logic                 clear,
  input  logic                 lockkey,
  output logic [DIGITS*DW-1:0] pw_bus,
  output logic [CNT_W-1:0]     digit_cnt,
  output logic                 full,
  output logic                 entry_done,
  output logic                 timeout
);

  // The idle counter only has to reach TIMEOUT_CYC-1, so it never wraps.
  localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_FULL,
    S_LOCKED
  } state_t;

  state_t                 state, state_nxt;
  logic [IDLE_W-1:0]      idle_cnt, idle_nxt;
  logic [DIGITS*DW-1:0]   pw_nxt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   done_nxt, to_nxt;

  // State implied by a digit count; used when leaving LOCKED and after edits.
  function automatic state_t state_of(input logic [CNT_W-1:0] cnt);
    if (cnt == '0)            return S_IDLE;
    else if (cnt == CNT_FULL) return S_FULL;
    else                      return S_ENTRY;
  endfunction

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    pw_nxt    = pw_bus;
    cnt_nxt   = digit_cnt;
    idle_nxt  = idle_cnt;
    done_nxt  = 1'b0;
    to_nxt    = 1'b0;

    if (clear) begin
      // The buffer is wiped even when locked; lockkey only decides the state.
      pw_nxt    = '0;
      cnt_nxt   = '0;
      idle_nxt  = '0;
      state_nxt = lockkey ? S_LOCKED : S_IDLE;
    end else if (lockkey) begin
      state_nxt = S_LOCKED;
    end else begin
      unique case (state)
        // The release cycle only re-derives the state; keys resume next cycle.
        S_LOCKED: state_nxt = state_of(digit_cnt);
        default: begin
          if (backspace) begin
            // A backspace wins over a simultaneous key, which is lost.
            if (digit_cnt != '0) begin
              for (int i = 0; i < DIGITS; i++) begin
                if (digit_cnt == CNT_W'(i + 1)) pw_nxt[i*DW +: DW] = '0;
              end
              cnt_nxt   = digit_cnt - 1'b1;
              idle_nxt  = '0;
              state_nxt = state_of(cnt_nxt);
            end
          end else if (key_valid && state != S_FULL) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (digit_cnt == CNT_W'(i)) pw_nxt[i*DW +: DW] = keyvalue;
            end
            cnt_nxt   = digit_cnt + 1'b1;
            idle_nxt  = '0;
            state_nxt = state_of(cnt_nxt);
            done_nxt  = (cnt_nxt == CNT_FULL);
          end else if (TO_EN && state == S_ENTRY) begin
            if (idle_cnt == IDLE_LAST) begin
              pw_nxt    = '0;
              cnt_nxt   = '0;
              idle_nxt  = '0;
              to_nxt    = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              idle_nxt = idle_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pw_bus     <= '0;
      digit_cnt  <= '0;
      idle_cnt   <= '0;
      full       <= 1'b0;
      entry_done <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pw_bus     <= pw_nxt;
      digit_cnt  <= cnt_nxt;
      idle_cnt   <= idle_nxt;
      full       <= (cnt_nxt == CNT_FULL);
      entry_done <= done_nxt;
      timeout    <= to_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_pw_buffer.sv
// -----------------------------------------------------------------------------
// tb_keypad_pw_buffer
// Directed bench for keypad_pw_buffer. Instance dut uses 4x4-bit digits with a
// 16-cycle timeout. Instance dut6 uses 6x8-bit digits with the timeout disabled.
// Inputs change 1 ns after a rising edge, and outputs are checked at that same
// point.
// -----------------------------------------------------------------------------
module tb_keypad_pw_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid, backspace, clear, lockkey;
  logic [3:0]  keyvalue;
  logic [15:0] pw_bus;
  logic [2:0]  digit_cnt;
  logic        full, entry_done, timeout;

  logic        key_valid6;
  logic [7:0]  keyvalue6;
  logic [47:0] pw_bus6;
  logic [2:0]  digit_cnt6;
  logic        full6, entry_done6, timeout6;

  int checks = 0;
  int errors = 0;
  logic saw_to;

  always #5 clk = ~clk;

  keypad_pw_buffer #(.DIGITS(4), .DW(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .keyvalue(keyvalue),
    .backspace(backspace), .clear(clear), .lockkey(lockkey),
    .pw_bus(pw_bus), .digit_cnt(digit_cnt), .full(full),
    .entry_done(entry_done), .timeout(timeout)
  );

  keypad_pw_buffer #(.DIGITS(6), .DW(8), .TIMEOUT_CYC(0)) dut6 (
    .clk(clk), .reset(reset), .key_valid(key_valid6), .keyvalue(keyvalue6),
    .backspace(1'b0), .clear(1'b0), .lockkey(1'b0),
    .pw_bus(pw_bus6), .digit_cnt(digit_cnt6), .full(full6),
    .entry_done(entry_done6), .timeout(timeout6)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    keyvalue  = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic bksp();
    backspace = 1'b1;
    tick();
    backspace = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic press6(input logic [7:0] k);
    key_valid6 = 1'b1;
    keyvalue6  = k;
    tick();
    key_valid6 = 1'b0;
  endtask

  // Runs n idle cycles and records whether timeout pulsed in any of them.
  task automatic idle(input int n);
    saw_to = 1'b0;
    repeat (n) begin
      tick();
      saw_to = saw_to | timeout;
    end
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; keyvalue = '0; backspace = 1'b0;
    clear = 1'b0; lockkey = 1'b0; key_valid6 = 1'b0; keyvalue6 = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1: reset state, four-digit entry, ignored fifth key
    check("rst_pw",   pw_bus, 16'h0);
    check("rst_cnt",  digit_cnt, 3'd0);
    check("rst_full", full, 1'b0);
    check("rst_done", entry_done, 1'b0);
    check("rst_to",   timeout, 1'b0);
    press(4'd3);
    check("k1_lat", pw_bus, 16'h0003);
    press(4'd7);
    press(4'd1);
    check("k3_done", entry_done, 1'b0);
    check("k3_full", full, 1'b0);
    press(4'd9);
    check("k4_pw",   pw_bus, 16'h9173);
    check("k4_cnt",  digit_cnt, 3'd4);
    check("k4_full", full, 1'b1);
    check("k4_done", entry_done, 1'b1);
    tick();
    check("done_1cyc", entry_done, 1'b0);
    press(4'd5);
    check("k5_pw",   pw_bus, 16'h9173);
    check("k5_cnt",  digit_cnt, 3'd4);
    check("k5_done", entry_done, 1'b0);

    // 2: backspace, including past empty
    do_clear();
    check("clr_cnt", digit_cnt, 3'd0);
    check("clr_pw",  pw_bus, 16'h0);
    press(4'd2); press(4'd4); press(4'd6);
    bksp();
    check("bs_pw",   pw_bus, 16'h0042);
    check("bs_cnt",  digit_cnt, 3'd2);
    bksp(); bksp(); bksp();
    check("bs0_pw",  pw_bus, 16'h0);
    check("bs0_cnt", digit_cnt, 3'd0);
    idle(20);
    check("idle_no_to", saw_to, 1'b0);
    press(4'd1);
    check("after_bs_pw", pw_bus, 16'h0001);
    check("after_bs_cnt", digit_cnt, 3'd1);

    // Backspace from FULL drops full
    press(4'd2); press(4'd3); press(4'd4);
    check("full_again", full, 1'b1);
    bksp();
    check("bs_full_drop", full, 1'b0);
    check("bs_full_pw", pw_bus, 16'h0321);

    // 3: lock freeze
    do_clear();
    press(4'd1); press(4'd2);
    lockkey = 1'b1;
    tick();
    press(4'd8); press(4'd8);
    bksp();
    check("lock_pw",  pw_bus, 16'h0021);
    check("lock_cnt", digit_cnt, 3'd2);
    idle(20);
    check("lock_no_to", saw_to, 1'b0);
    lockkey = 1'b0;
    tick();
    press(4'd5);
    check("unlock_pw",  pw_bus, 16'h0521);
    check("unlock_cnt", digit_cnt, 3'd3);

    // 4: inactivity timeout (16 cycles)
    do_clear();
    press(4'd4);
    idle(15);
    check("to_early", saw_to, 1'b0);
    check("to_early_cnt", digit_cnt, 3'd1);
    tick();
    check("to_pulse", timeout, 1'b1);
    check("to_pw",    pw_bus, 16'h0);
    check("to_cnt",   digit_cnt, 3'd0);
    tick();
    check("to_1cyc",  timeout, 1'b0);
    press(4'd4);
    idle(9);
    press(4'd6);
    idle(15);
    check("to2_early", saw_to, 1'b0);
    check("to2_pw",    pw_bus, 16'h0064);
    tick();
    check("to2_pulse", timeout, 1'b1);
    check("to2_cnt",   digit_cnt, 3'd0);

    // 5: priority corners and reset mid-entry
    press(4'd1); press(4'd2);
    key_valid = 1'b1; keyvalue = 4'd7; backspace = 1'b1;
    tick();
    key_valid = 1'b0; backspace = 1'b0;
    check("kv_bs_cnt", digit_cnt, 3'd1);
    check("kv_bs_pw",  pw_bus, 16'h0001);
    key_valid = 1'b1; keyvalue = 4'd3; clear = 1'b1;
    tick();
    key_valid = 1'b0; clear = 1'b0;
    check("clr_kv_cnt", digit_cnt, 3'd0);
    check("clr_kv_pw",  pw_bus, 16'h0);
    press(4'd1); press(4'd2); press(4'd3);
    check("pre_rst_pw", pw_bus, 16'h0321);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_pw",  pw_bus, 16'h0);
    check("mid_rst_cnt", digit_cnt, 3'd0);
    check("mid_rst_full", full, 1'b0);

    // 6: 6x8-bit instance, timeout disabled
    press6(8'hA0); press6(8'hA1); press6(8'hA2);
    saw_to = 1'b0;
    repeat (40) begin
      tick();
      saw_to = saw_to | timeout6;
    end
    check("w6_no_to",  saw_to, 1'b0);
    check("w6_cnt3",   digit_cnt6, 3'd3);
    press6(8'hA3); press6(8'hA4);
    check("w6_done5",  entry_done6, 1'b0);
    check("w6_full5",  full6, 1'b0);
    press6(8'hA5);
    check("w6_pw",     pw_bus6, 48'hA5A4A3A2A1A0);
    check("w6_cnt",    digit_cnt6, 3'd6);
    check("w6_full",   full6, 1'b1);
    check("w6_done",   entry_done6, 1'b1);
    tick();
    check("w6_done1",  entry_done6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
